// File: rtl/sid_audio_pkg.sv
// Shared widths and FSM encoding for the SID audio decimator.
package sid_audio_pkg;
    localparam int AUD_W      = 18;
    localparam int CNT_W      = 6;
    localparam int SUM_W      = 24;
    localparam int FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        PUSH
    } state_t;
endpackage

// File: rtl/sid_audio_fifo.sv
// 4-entry sample FIFO with registered head output.
module sid_audio_fifo
    import sid_audio_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [AUD_W-1:0] wdata,
    input  logic             pop,
    output logic [AUD_W-1:0] rdata,
    output logic             valid,
    output logic             drop
);
    logic [AUD_W-1:0] mem [FIFO_DEPTH];
    logic [1:0] rd_ptr;
    logic [1:0] wr_ptr;
    logic [2:0] count;
    logic empty;
    logic full;
    logic do_push;
    logic do_pop;

    assign empty   = (count == 3'd0);
    assign full    = (count == 3'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;
    assign valid   = !empty;

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            rdata  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 2'd1;
            if (do_pop)
                rd_ptr <= rd_ptr + 2'd1;
            count <= count + 3'(do_push) - 3'(do_pop);
            if (do_pop) begin
                if (count > 3'd1)
                    rdata <= mem[rd_ptr + 2'd1];
                else if (do_push)
                    rdata <= wdata;
            end else if (do_push && empty) begin
                rdata <= wdata;
            end
        end
    end
endmodule

// File: rtl/sid_audio_decim.sv
// Window-averaging decimator: 1 MHz SID samples down to OUT_HZ.
module sid_audio_decim
    import sid_audio_pkg::*;
#(
    parameter int CLK_HZ = 31527954,
    parameter int OUT_HZ = 48000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ce_1m,
    input  logic [AUD_W-1:0] audio_in,
    output logic [AUD_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun
);
    logic [31:0] ph;
    logic [31:0] ph_sum;
    logic tick;

    assign ph_sum = ph + 32'(OUT_HZ);
    assign tick   = (ph_sum >= 32'(CLK_HZ));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ph <= '0;
        else
            ph <= tick ? ph_sum - 32'(CLK_HZ) : ph_sum;
    end

    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum <= '0;
            cnt <= '0;
        end else if (tick) begin
            sum <= ce_1m ? SUM_W'(audio_in) : '0;
            cnt <= ce_1m ? CNT_W'(1) : '0;
        end else if (ce_1m && cnt != '1) begin
            sum <= sum + SUM_W'(audio_in);
            cnt <= cnt + CNT_W'(1);
        end
    end

    state_t state;
    logic [SUM_W-1:0] dq;
    logic [CNT_W-1:0] dvs;
    logic [CNT_W-1:0] rem;
    logic [4:0] bitc;
    logic [AUD_W-1:0] hold;
    logic [AUD_W-1:0] push_data;
    logic fifo_push;
    logic fifo_drop;
    logic [CNT_W:0] shl;
    logic ge;

    // dq holds the dividend and collects quotient bits as it shifts out
    assign shl = {rem, dq[SUM_W-1]};
    assign ge  = (shl >= {1'b0, dvs});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            dq        <= '0;
            dvs       <= '0;
            rem       <= '0;
            bitc      <= '0;
            hold      <= '0;
            push_data <= '0;
            fifo_push <= 1'b0;
        end else begin
            fifo_push <= 1'b0;
            if (tick) begin
                dvs   <= cnt;
                rem   <= '0;
                bitc  <= '0;
                dq    <= (cnt != '0) ? sum : SUM_W'(hold);
                state <= (cnt != '0) ? DIV : PUSH;
            end else begin
                unique case (state)
                    IDLE: ;
                    DIV: begin
                        dq   <= {dq[SUM_W-2:0], ge};
                        rem  <= ge ? CNT_W'(shl - {1'b0, dvs})
                                   : shl[CNT_W-1:0];
                        bitc <= bitc + 5'd1;
                        if (bitc == 5'd23)
                            state <= PUSH;
                    end
                    PUSH: begin
                        fifo_push <= 1'b1;
                        push_data <= dq[AUD_W-1:0];
                        hold      <= dq[AUD_W-1:0];
                        state     <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            overrun <= 1'b0;
        else if (fifo_drop || (tick && state != IDLE))
            overrun <= 1'b1;
    end

    sid_audio_fifo u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .wdata   (push_data),
        .pop     (out_ready),
        .rdata   (out_data),
        .valid   (out_valid),
        .drop    (fifo_drop)
    );
endmodule

// File: tb/tb_sid_audio_decim.sv
// Scoreboard bench for sid_audio_decim with a window-average model.
module tb_sid_audio_decim;
    localparam int CLK_HZ = 10000;
    localparam int OUT_HZ = 137;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ce_1m = 1'b0;
    logic [17:0] audio_in = '0;
    logic [17:0] out_data;
    logic out_valid;
    logic out_ready = 1'b0;
    logic overrun;

    int checks = 0;
    int errors = 0;

    sid_audio_decim #(.CLK_HZ(CLK_HZ), .OUT_HZ(OUT_HZ)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ce_1m     (ce_1m),
        .audio_in  (audio_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int edge_n;
        int val;
    } pend_t;

    pend_t pend[$];
    int exp_q[$];
    int k = 0;
    int mocc = 0;
    int hold = 0;
    bit ovr_exp = 1'b0;
    longint wsum = 0;
    int wcnt = 0;
    int mv;
    int sv;

    // an output tick falls on every edge where k*OUT/CLK crosses an integer
    function automatic bit is_tick(input int n);
        longint a;
        longint b;
        a = (longint'(n) * OUT_HZ) / CLK_HZ;
        b = ((longint'(n) + 1) * OUT_HZ) / CLK_HZ;
        return a != b;
    endfunction

    initial forever begin
        @(posedge clk);
        if (!reset_n) begin
            k = 0;
            mocc = 0;
            hold = 0;
            ovr_exp = 1'b0;
            wsum = 0;
            wcnt = 0;
            pend.delete();
            exp_q.delete();
        end else begin
            if (out_ready && mocc > 0)
                mocc--;
            while (pend.size() > 0 && pend[0].edge_n == k) begin
                mv = pend[0].val;
                void'(pend.pop_front());
                if (mocc < 4) begin
                    mocc++;
                    exp_q.push_back(mv);
                end else begin
                    ovr_exp = 1'b1;
                end
            end
            if (is_tick(k)) begin
                mv = (wcnt != 0) ? int'(wsum / wcnt) : hold;
                hold = mv;
                pend.push_back('{k + ((wcnt != 0) ? 26 : 2), mv});
                wsum = ce_1m ? longint'(audio_in) : 0;
                wcnt = ce_1m ? 1 : 0;
            end else if (ce_1m && wcnt < 63) begin
                wsum += audio_in;
                wcnt++;
            end
            k++;
        end
    end

    logic prev_stall = 1'b0;
    logic [17:0] prev_data = '0;

    initial forever begin
        @(negedge clk);
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            checks++;
            if (out_valid !== (mocc != 0)) begin
                errors++;
                $display("FAIL valid: got %b want %b at %0t",
                         out_valid, mocc != 0, $time);
            end
            checks++;
            if (overrun !== ovr_exp) begin
                errors++;
                $display("FAIL overrun: got %b want %b at %0t",
                         overrun, ovr_exp, $time);
            end
            if (prev_stall && out_valid) begin
                checks++;
                if (out_data !== prev_data) begin
                    errors++;
                    $display("FAIL stall_hold: got %h want %h at %0t",
                             out_data, prev_data, $time);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop: got %h want none at %0t",
                             out_data, $time);
                end else begin
                    sv = exp_q.pop_front();
                    if (out_data !== 18'(sv)) begin
                        errors++;
                        $display("FAIL data: got %h want %h at %0t",
                                 out_data, 18'(sv), $time);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input bit ce, input int a);
        ce_1m = ce;
        audio_in = 18'(a);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input bit rnd);
        int n = 0;
        while (!is_tick(k) && n < 300) begin
            if (rnd)
                cyc($urandom_range(0, 7) == 0, int'($urandom_range(0, 262143)));
            else
                cyc(1'b0, 0);
            n++;
        end
        if (!is_tick(k)) begin
            checks++;
            errors++;
            $display("FAIL wait_tick: got none want tick in %0d clks", n);
        end
    endtask

    task automatic tick_check(input bit ce, input int a,
                              input int expv, input int lat);
        int c;
        cyc(ce, a);
        c = 1;
        while (!out_valid && c < 100) begin
            cyc(1'b0, 0);
            c++;
        end
        checks++;
        if (c != lat) begin
            errors++;
            $display("FAIL latency: got %0d want %0d", c, lat);
        end
        checks++;
        if (out_data !== 18'(expv)) begin
            errors++;
            $display("FAIL tick_data: got %0d want %0d", out_data, expv);
        end
    endtask

    task automatic expect_bit(input string name, input logic got,
                              input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        expect_bit("rst_valid", out_valid, 1'b0);
        expect_bit("rst_overrun", overrun, 1'b0);
        checks++;
        if (out_data !== 18'd0) begin
            errors++;
            $display("FAIL rst_data: got %h want 0", out_data);
        end

        out_ready = 1'b1;
        for (int i = 0; i < 450; i++)
            cyc((i % 32) == 0, 'h2AAAA);

        wait_tick(1'b0);
        cyc(1'b0, 0);
        cyc(1'b1, 0);
        cyc(1'b0, 0);
        cyc(1'b1, 10);
        cyc(1'b0, 0);
        cyc(1'b0, 0);
        cyc(1'b1, 20);
        cyc(1'b1, 31);
        wait_tick(1'b0);
        tick_check(1'b0, 0, 15, 27);

        cyc(1'b1, 100);
        wait_tick(1'b0);
        tick_check(1'b0, 0, 100, 27);
        wait_tick(1'b0);
        tick_check(1'b0, 0, 100, 3);

        cyc(1'b1, 40);
        cyc(1'b1, 50);
        wait_tick(1'b0);
        tick_check(1'b1, 7, 45, 27);
        cyc(1'b1, 9);
        wait_tick(1'b0);
        tick_check(1'b0, 0, 8, 27);

        for (int i = 0; i < 1500; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (i >= 300 && i < 500)
                cyc(1'b1, int'($urandom_range(0, 262143)));
            else
                cyc($urandom_range(0, 15) == 0,
                    int'($urandom_range(0, 262143)));
        end

        out_ready = 1'b1;
        wait_tick(1'b0);
        cyc(1'b0, 0);
        repeat (30) cyc(1'b0, 0);
        out_ready = 1'b0;
        for (int t = 0; t < 5; t++) begin
            wait_tick(1'b1);
            cyc(1'b0, 0);
        end
        repeat (30) cyc(1'b0, 0);
        expect_bit("bp_overrun", overrun, 1'b1);
        expect_bit("bp_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        repeat (10) cyc(1'b0, 0);
        expect_bit("bp_drained", out_valid, 1'b0);

        out_ready = 1'b0;
        wait_tick(1'b0);
        cyc(1'b0, 0);
        repeat (10) cyc(1'b1, 5);
        wait_tick(1'b0);
        cyc(1'b0, 0);
        repeat (10) cyc(1'b0, 0);
        expect_bit("pre_rst_valid", out_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        expect_bit("async_valid", out_valid, 1'b0);
        expect_bit("async_overrun", overrun, 1'b0);
        checks++;
        if (out_data !== 18'd0) begin
            errors++;
            $display("FAIL async_data: got %h want 0", out_data);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        cyc(1'b1, 1000);
        cyc(1'b1, 2000);
        cyc(1'b1, 3003);
        wait_tick(1'b0);
        tick_check(1'b0, 0, 2001, 27);

        repeat (100) cyc(1'b0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sid_audio_decim.md
# sid_audio_decim

Downstream of the SID voice/filter core: accumulates the 18-bit mixed audio sample presented on every `ce_1m` strobe, closes an averaging window on each fractional output-rate tick, and divides the window sum by its sample count with a sequential divider. Averaged samples go to a 4-entry FIFO with a valid/ready handshake toward the audio output path (I2S/HDMI mixer).

## Interface
- `CLK_HZ`, default 31527954: system clock frequency, in Hz.
- `OUT_HZ`, default 48000: output sample rate, in Hz. Must satisfy OUT_HZ < CLK_HZ/64.
- `clk`  input  1: system clock, the same clock that runs the SID core.
- `reset_n`  input  1: asynchronous, active-low reset.
- `ce_1m`  input  1: single-cycle strobe marking a valid `audio_in` sample.
- `audio_in`  input  18: unsigned audio sample from the SID core.
- `out_data`  output  18: averaged sample at the FIFO head.
- `out_valid`  output  1: FIFO not empty.
- `out_ready`  input  1: the consumer accepts the head entry when `out_valid && out_ready`.
- `overrun`  output  1: sticky error flag, set on a FIFO drop or a divider overrun.

## Operation
- **Rate tick**
  - 32-bit phase accumulator `ph`. Each clk: `ph += OUT_HZ`.
  - When the result is `>= CLK_HZ`, subtract `CLK_HZ` and assert `tick` for one cycle.
- **Window accumulation**
  - `sum` is 24 bits and `cnt` is 6 bits.
  - On `ce_1m`: `sum += audio_in` and `cnt += 1`.
  - When `cnt == 63`, further samples are ignored until the next tick (`cnt` saturates, `sum` holds).
- **Window close on `tick`**
  - Snapshot `sum`/`cnt` into the divider operands.
  - Clear the window to `sum=0`, `cnt=0`.
  - **Simultaneous `ce_1m` and `tick`:** the snapshot excludes the new sample, and the new window starts at `sum=audio_in`, `cnt=1`.
- **Divider FSM**
  - IDLE: on `tick` with snapshot `cnt != 0`, go to DIV. On `tick` with `cnt == 0`, go to PUSH with quotient = last pushed value (the hold value).
  - DIV: restoring division, 24-bit by 6-bit, one quotient bit per clk, MSB first, 24 cycles, then go to PUSH.
  - PUSH: write the quotient `[17:0]` into the FIFO and return to IDLE. The quotient never exceeds 18 bits because it is a mean of 18-bit values.
  - **Tick while in DIV or PUSH:** abort the current division (discard it), set `overrun`, and restart from the new snapshot.
- **FIFO**
  - 4 entries, with 2-bit read/write pointers and a 3-bit occupancy counter.
  - **Push when full:** the new sample is dropped and `overrun` is set. FIFO contents are unchanged.
  - **Push and pop in the same cycle:** both happen, occupancy is unchanged. This is legal even when full, because the pop frees the slot first.
  - **Pop when empty:** no effect.
- `overrun` is cleared only by reset.

## Timing
- **Reset values:**
  - `ph=0`, `sum=0`, `cnt=0`, FSM=IDLE.
  - Hold value = 0.
  - FIFO empty: `out_valid=0`, `out_data=0`.
  - `overrun=0`.
- **Latency:** from the `tick` cycle to the PUSH register write is 26 clks (1 snapshot, 24 DIV, 1 PUSH). `out_valid` rises on the following edge, 27 clks after `tick`.
- **Hold path** (window with `cnt=0`): 2 clks from tick to push.
- `out_data` is registered and reflects the head entry. It changes only on a pop or when the FIFO goes from empty to non-empty.
- **Handshake:** `out_data` is stable while `out_valid && !out_ready`.
- **Reset mid-operation:** reset asserted during DIV aborts immediately, and all state returns to reset values asynchronously.
- **Expected window size:** with default parameters, ticks arrive every 656 or 657 clks and a window holds 20–21 samples at a 985 kHz `ce_1m`.

## Structure
- **Shared package `sid_audio_pkg`** holds:
  - localparams `AUD_W=18`, `CNT_W=6`, `SUM_W=24`, `FIFO_DEPTH=4`;
  - the FSM state enum {IDLE, DIV, PUSH}.
- **Sub-module `sid_audio_fifo`:** the 4-entry FIFO with registered output and full/empty logic. It is reused by the other audio sources in the core.
- The divider stays inline as FSM datapath.

## Test plan
- **Constant input:** `audio_in=18'h2AAAA`, `ce_1m` every 32 clks, `out_ready=1` → every output = `18'h2AAAA`, `overrun=0`.
- **Exact average:** force ticks around a window of 4 samples {0, 10, 20, 31} → `out_data=15` (61/4 truncated) at tick+27.
- **Empty window:** no `ce_1m` between two ticks after a previous output of 100 → hold output 100 pushed 2 clks after the tick.
- **Simultaneous events:** `ce_1m` with `audio_in=7` in the same cycle as `tick` → the closed window excludes 7; the next window's first sample is 7 with `cnt=1`.
- **Back-pressure:** `out_ready=0` for 5 ticks → 4 entries held in order, 5th dropped, `overrun=1`. Then `out_ready=1` → the 4 values drain unchanged.
- **Async reset:** assert `reset_n=0` mid-DIV, without a clock edge → `out_valid=0`, `overrun=0`. After release, the first output is correct for a fresh window.
